// File: rtl/demux16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux16_pkg
// Purpose  : Shared widths, FSM state encoding and mode constants for the
//            16-bit serial-to-parallel demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package demux16_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

endpackage : demux16_pkg
`default_nettype wire

// File: rtl/demux1to16_dec.sv
`default_nettype none
// ============================================================================
// Module   : demux1to16_dec
// Purpose  : Index + enable to one-hot write-enable decoder. One decoded
//            vector drives both the shadow-word and written-mask updates.
// Revision : 1.0 - initial release
// ============================================================================
module demux1to16_dec #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  // Each output bit compares the index against its own position.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (idx_i == SEL_W'(gi));
  end

endmodule : demux1to16_dec
`default_nettype wire

// File: rtl/demux16_deser.sv
`default_nettype none
// ============================================================================
// Module   : demux16_deser
// Purpose  : Sequential 1-to-16 demultiplexer / deserializer. Collects one
//            serial bit per valid cycle into a shadow word (auto-increment
//            LSB-first or explicitly addressed), and publishes the finished
//            word with a one-cycle strobe once every bit position is written.
// Revision : 1.0 - initial release
// ============================================================================
module demux16_deser #(
  parameter int N     = 16,  // word width; this revision supports 16 only
  parameter int SEL_W = 4    // log2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             in_i,
  input  logic             valid_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N-1:0]     out_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic [SEL_W-1:0] idx_o
);

  import demux16_pkg::*;

  state_e           state_q, state_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     mask_q, mask_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] wr_pos;
  logic             wr_en;
  logic [N-1:0]     wr_onehot;
  logic [N-1:0]     mask_merged;
  logic [N-1:0]     shadow_merged;
  logic             complete;

  // Write position: running index in auto mode, caller's select otherwise.
  always_comb begin
    wr_pos = (mode_q == MODE_ADDR) ? sel_i : idx_q;
    wr_en  = (state_q == ST_FILL) && valid_i;
  end

  demux1to16_dec #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_dec (
    .idx_i    (wr_pos),
    .en_i     (wr_en),
    .onehot_o (wr_onehot)
  );

  // Merge the current bit into the shadow word and mask. Completion is judged
  // on the merged mask, so a repeated address cannot complete a frame early.
  always_comb begin
    mask_merged   = mask_q | wr_onehot;
    shadow_merged = (shadow_q & ~wr_onehot) | ({N{in_i}} & wr_onehot);
    complete      = wr_en && (&mask_merged);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start always wins, so a completing frame can chain
  // straight into the next one without passing through IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_FILL;
      ST_FILL: begin
        if (start_i)       state_d = ST_FILL;
        else if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: all driven straight from registers.
  always_comb begin
    busy_o      = (state_q == ST_FILL);
    idx_o       = idx_q;
    out_o       = out_q;
    out_valid_o = out_valid_q;
  end

  // Datapath next state. The completion publish happens even when start
  // arrives in the same cycle; otherwise start discards the cycle's write.
  always_comb begin
    shadow_d    = shadow_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (complete) begin
      out_d       = shadow_merged;
      out_valid_d = 1'b1;
    end

    if (start_i) begin
      shadow_d = '0;
      mask_d   = '0;
      idx_d    = '0;
      mode_d   = mode_i;
    end else if (complete) begin
      shadow_d = '0;
      mask_d   = '0;
      idx_d    = '0;
    end else if (wr_en) begin
      shadow_d = shadow_merged;
      mask_d   = mask_merged;
      if (mode_q == MODE_AUTO) begin
        idx_d = idx_q + SEL_W'(1);
      end
    end
  end

  // Datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      mask_q      <= '0;
      mode_q      <= MODE_AUTO;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule : demux16_deser
`default_nettype wire

// File: tb/tb_demux16_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux16_deser
// Purpose  : Directed self-checking bench for demux16_deser: a table of whole
//            frames plus hand-written abort, duplicate-address, reset and
//            back-to-back sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux16_deser;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i  = 1'b0;
  logic        in_i    = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  sel_i   = 4'd0;
  logic [15:0] out_o;
  logic        out_valid_o;
  logic        busy_o;
  logic [3:0]  idx_o;

  int n_vec = 0;
  int n_bad = 0;

  demux16_deser #(
    .N     (16),
    .SEL_W (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .in_i        (in_i),
    .valid_i     (valid_i),
    .sel_i       (sel_i),
    .out_o       (out_o),
    .out_valid_o (out_valid_o),
    .busy_o      (busy_o),
    .idx_o       (idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;     // 0 auto, 1 addressed (sel 15..0)
    logic        gaps;     // every third cycle has valid low
    logic [15:0] word;
    logic [15:0] exp_out;
  } frame_t;

  frame_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame from start to the cycle after the strobe.
  task automatic send_frame(input frame_t f);
    int pulses;
    int k;
    pulses  = 0;
    k       = 0;
    start_i = 1'b1;
    mode_i  = f.mode;
    valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("idx_after_start", idx_o, 0);
    for (int i = 0; i < 16; i++) begin
      if (f.gaps && (k % 3 == 2)) begin
        valid_i = 1'b0;
        in_i    = ~in_i;
        tick();
        k++;
        pulses += int'(out_valid_o);
        check("idx_frozen_in_gap", idx_o, (f.mode == 1'b0) ? i : 0);
      end
      valid_i = 1'b1;
      in_i    = f.mode ? f.word[15-i] : f.word[i];
      sel_i   = 4'(15 - i);
      tick();
      k++;
      valid_i = 1'b0;
      if (i < 15) pulses += int'(out_valid_o);
    end
    check("no_early_out_valid", pulses, 0);
    check("out_valid_on_last", out_valid_o, 1);
    check("out_word", out_o, f.exp_out);
    check("busy_after_done", busy_o, 0);
    check("idx_after_done", idx_o, 0);
    tick();
    check("out_valid_one_cycle", out_valid_o, 0);
    check("out_hold", out_o, f.exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int         pulses;
    logic [15:0] w;

    tbl[0] = '{1'b0, 1'b0, 16'h3f0a, 16'h3f0a};
    tbl[1] = '{1'b0, 1'b1, 16'hA5C3, 16'hA5C3};
    tbl[2] = '{1'b1, 1'b0, 16'h8001, 16'h8001};
    tbl[3] = '{1'b1, 1'b1, 16'h6C39, 16'h6C39};

    // Reset state, with valid asserted to show it has no effect.
    valid_i = 1'b1;
    in_i    = 1'b1;
    tick();
    tick();
    check("rst_out", out_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_idx", idx_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_valid_ignored_busy", busy_o, 0);
    check("idle_valid_ignored_idx", idx_o, 0);
    check("idle_valid_ignored_ov", out_valid_o, 0);
    valid_i = 1'b0;

    for (int t = 0; t < 4; t++) send_frame(tbl[t]);

    // Addressed mode: index 6 written twice, completion needs all 16 indices.
    // Data from 16'h5555, bit 6 overwritten with 0 -> 16'h5515.
    w       = 16'h5555;
    pulses  = 0;
    start_i = 1'b1;
    mode_i  = 1'b1;
    tick();
    start_i = 1'b0;
    valid_i = 1'b1;
    sel_i   = 4'd6; in_i = 1'b1; tick(); pulses += int'(out_valid_o);
    sel_i   = 4'd6; in_i = 1'b0; tick(); pulses += int'(out_valid_o);
    check("addr_idx_holds_zero", idx_o, 0);
    for (int j = 0; j < 16; j++) begin
      if (j != 6) begin
        sel_i = 4'(j);
        in_i  = w[j];
        tick();
        if (j != 15) pulses += int'(out_valid_o);
      end
    end
    valid_i = 1'b0;
    check("dup_no_early_out_valid", pulses, 0);
    check("dup_out_valid", out_valid_o, 1);
    check("dup_out_word", out_o, 16'h5515);
    tick();

    // Abort: 8 bits, restart (valid in that cycle ignored), then 16'h1234.
    w       = 16'h1234;
    pulses  = 0;
    start_i = 1'b1;
    mode_i  = 1'b0;
    tick();
    start_i = 1'b0;
    valid_i = 1'b1;
    in_i    = 1'b1;
    repeat (8) begin tick(); pulses += int'(out_valid_o); end
    start_i = 1'b1;
    tick();
    pulses += int'(out_valid_o);
    start_i = 1'b0;
    check("abort_busy", busy_o, 1);
    check("abort_idx_cleared", idx_o, 0);
    for (int i = 0; i < 16; i++) begin
      in_i = w[i];
      tick();
      pulses += int'(out_valid_o);
    end
    valid_i = 1'b0;
    check("abort_out_word", out_o, 16'h1234);
    tick();
    pulses += int'(out_valid_o);
    check("abort_single_pulse", pulses, 1);

    // Asynchronous reset mid-frame after 10 bits.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    valid_i = 1'b1;
    in_i    = 1'b1;
    repeat (10) tick();
    valid_i = 1'b0;
    check("pre_reset_idx", idx_o, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_idx", idx_o, 0);
    check("async_rst_out_valid", out_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_frame('{1'b0, 1'b0, 16'hFFFF, 16'hFFFF});

    // Back-to-back: start in the completion cycle of 16'h00F0, then 16'h0F00.
    w       = 16'h00F0;
    start_i = 1'b1;
    mode_i  = 1'b0;
    tick();
    start_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_i = w[i];
      tick();
    end
    in_i    = w[15];
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("b2b_first_out_valid", out_valid_o, 1);
    check("b2b_first_word", out_o, 16'h00F0);
    check("b2b_busy_between", busy_o, 1);
    check("b2b_idx_restart", idx_o, 0);
    w      = 16'h0F00;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      in_i = w[i];
      tick();
      if (i < 15) begin
        pulses += int'(out_valid_o);
        if (busy_o !== 1'b1) check("b2b_busy_held", busy_o, 1);
      end
    end
    valid_i = 1'b0;
    check("b2b_gap_pulses", pulses, 0);
    check("b2b_second_out_valid", out_valid_o, 1);
    check("b2b_second_word", out_o, 16'h0F00);
    check("b2b_busy_after", busy_o, 0);
    tick();
    check("b2b_pulse_width", out_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_demux16_deser
`default_nettype wire

// File: doc/demux16_deser.md
# demux16_deser

Sequential 1-to-16 demultiplexer and deserializer, the receiving end of the 16:1 bit-select mux path. It captures one serial bit per valid cycle and writes it into a 16-bit word, either at an auto-incrementing index (LSB first) or at an explicit select index. It presents the completed word with a one-cycle strobe. It sits downstream of any mux-driven serializer and reconstructs the original 16-bit vector.

## Interface
- `N`, default 16: word width. Fixed at 16 for this revision.
- `SEL_W`, default 4: select/index width, equal to log2(`N`).
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `start`, in, 1: begin a new frame. Clears the shadow word and the written-mask, and latches `mode`.
- `mode`, in, 1: 0 = auto index (0..15), 1 = addressed by `sel`. Sampled only with `start`.
- `in`, in, 1: serial data bit.
- `valid`, in, 1: `in` (and `sel` in addressed mode) are valid this cycle.
- `sel`, in, `SEL_W`: target bit index in addressed mode. Ignored in auto mode.
- `out`, out, `N`: last completed word. Holds its value until the next completion.
- `out_valid`, out, 1: one-cycle pulse when `out` updates.
- `busy`, out, 1: high while in FILL.
- `idx`, out, `SEL_W`: next auto write index. In addressed mode it holds 0.

## Operation
- States: IDLE and FILL.
- IDLE:
  - `valid` is ignored.
  - `start` moves to FILL. On entry: shadow = 0, mask = 0, `idx` = 0, mode register = `mode`.
- FILL:
  - Each cycle with `valid`=1, write `in` into the shadow word at position p, where p = `idx` (auto mode) or `sel` (addressed mode), and set mask[p].
  - Auto mode: `idx` increments by 1 per valid cycle. It wraps 15→0 only on frame completion.
  - Addressed mode: rewriting an already-written index overwrites the data bit. The mask is unchanged, so the write does not count toward completion.
  - Completion: if the mask, including the current write, becomes all ones, then at that same edge:
    - `out` = shadow word with the current bit merged;
    - `out_valid` = 1;
    - state → IDLE; `idx` → 0.
  - `valid`=0 cycles (gaps) leave all state unchanged.
- Simultaneous events:
  - `start` in FILL aborts the current frame and restarts it (clears shadow and mask, relatches `mode`). `valid` in that cycle is ignored. `out` is not updated.
  - `start` in the completion cycle: the completion takes effect, `start` has priority for the next state, and the FSM goes to FILL with shadow and mask cleared.
- Reset (any time, including mid-frame):
  - state = IDLE;
  - `out` = 16'h0000, `out_valid` = 0, `busy` = 0, `idx` = 0;
  - shadow, mask and mode register = 0.
  - A partial frame is discarded.

## Timing
- Latency from the edge sampling the final valid bit to `out`/`out_valid` visible: 0 cycles. Both are registered at that edge.
- `out_valid` lasts exactly one cycle. It is never high in two consecutive cycles.
- Minimum frame length: 1 cycle for `start` plus 16 valid cycles, giving 17 cycles from `start` to `out_valid`.
- `busy` rises the cycle after `start` is sampled. It falls with `out_valid`, unless a simultaneous `start` keeps it high.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `demux16_pkg` holds:
  - `N`, `SEL_W`;
  - state typedef `{ST_IDLE, ST_FILL}`;
  - mode constants `MODE_AUTO`=0 and `MODE_ADDR`=1.
- Sub-module `demux1to16_dec`: combinational decoder from a 4-bit index plus enable to a 16-bit one-hot write-enable. It is shared by the shadow-word update and the mask update.
- The top level contains the FSM, the shadow/mask registers, the index counter and the output register.

## Test plan
- Auto mode, reset → `start`, then serialize 16'h3f0a LSB-first over 16 consecutive valid cycles → `out`=16'h3f0a and a single `out_valid` pulse exactly 17 cycles after `start`; `busy` low afterwards.
- Auto mode with `valid` gaps (every third cycle low), word 16'hA5C3 → `out`=16'hA5C3; `idx` frozen during gaps; no early `out_valid`.
- Addressed mode:
  - `sel` order 15..0, data from 16'h8001 → `out`=16'h8001;
  - repeat with `sel`=6 written twice (first 1, then 0) plus all other indices → bit 6 = 0, and completion occurs only after all 16 distinct indices are written.
- Abort: `start`, 8 valid bits, then `start` again, then 16 bits of 16'h1234 → `out`=16'h1234; only one `out_valid` pulse.
- Reset mid-frame: assert `rst_n`=0 after 10 bits → `out`=0, `busy`=0, `idx`=0 immediately (asynchronous); after release, a full frame of 16'hFFFF gives `out`=16'hFFFF.
- Back-to-back: assert `start` in the completion cycle of frame 16'h00F0, then send 16'h0F00 → two `out_valid` pulses separated by exactly 16 valid cycles; `busy` stays high between frames.
